// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round controller: owns the cipher state register and
// sequences the shared SubBytes/ShiftRows/MixColumns/AddRoundKey units.
module aes_round_sequencer #(
    parameter int WORD_SIZE  = 8,
    parameter int ARRAY_SIZE = 16,
    parameter int NR         = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [WORD_SIZE*ARRAY_SIZE-1:0] data_in,
    output logic                            busy,
    output logic                            done,
    output logic [WORD_SIZE*ARRAY_SIZE-1:0] data_out,
    output logic                            stage_start,
    output logic [1:0]                      stage_sel,
    output logic [WORD_SIZE*ARRAY_SIZE-1:0] stage_data,
    input  logic [WORD_SIZE*ARRAY_SIZE-1:0] stage_result,
    input  logic                            stage_done,
    output logic [3:0]                      round
);

    // state | meaning
    // IDLE  | waiting for start; data_out holds the last ciphertext
    // ISSUE | stage_start pulse for the op held in stage_sel
    // WAIT  | op outstanding; stage_sel/stage_data held until stage_done
    // FIN   | done pulse; ciphertext presented on data_out
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} fsm_t;

    localparam logic [1:0] OP_SUB   = 2'd0;
    localparam logic [1:0] OP_SHIFT = 2'd1;
    localparam logic [1:0] OP_MIX   = 2'd2;
    localparam logic [1:0] OP_ARK   = 2'd3;
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    fsm_t                            fsm, fsm_d;
    logic [1:0]                      sel_d;
    logic [3:0]                      round_d;
    logic [WORD_SIZE*ARRAY_SIZE-1:0] state_d, out_d;
    logic                            busy_d, done_d, start_d;

    // stage_data is the state register itself; every output is computed
    // one cycle ahead so that all of them come straight from flops.
    always_comb begin
        fsm_d   = fsm;
        sel_d   = stage_sel;
        round_d = round;
        state_d = stage_data;
        out_d   = data_out;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        start_d = 1'b0;
        case (fsm)
            IDLE: begin
                if (start) begin
                    state_d = data_in;
                    round_d = 4'd0;
                    sel_d   = OP_ARK;
                    fsm_d   = ISSUE;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                end
            end
            ISSUE: begin
                fsm_d  = WAIT;
                busy_d = 1'b1;
            end
            WAIT: begin
                busy_d = 1'b1;
                if (stage_done) begin
                    state_d = stage_result;
                    fsm_d   = ISSUE;
                    start_d = 1'b1;
                    case (stage_sel)
                        OP_SUB:   sel_d = OP_SHIFT;
                        OP_SHIFT: sel_d = (round < LAST_ROUND) ? OP_MIX : OP_ARK;
                        OP_MIX:   sel_d = OP_ARK;
                        default: begin
                            if (round == LAST_ROUND) begin
                                fsm_d   = FIN;
                                start_d = 1'b0;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                out_d   = stage_result;
                            end else begin
                                round_d = round + 4'd1;
                                sel_d   = OP_SUB;
                            end
                        end
                    endcase
                end
            end
            FIN: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= IDLE;
            stage_sel   <= OP_SUB;
            round       <= 4'd0;
            stage_data  <= '0;
            data_out    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            stage_start <= 1'b0;
        end else begin
            fsm         <= fsm_d;
            stage_sel   <= sel_d;
            round       <= round_d;
            stage_data  <= state_d;
            data_out    <= out_d;
            busy        <= busy_d;
            done        <= done_d;
            stage_start <= start_d;
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: models the four stage units and the key
// schedule, and compares ciphertext, op trace and timing against an AES model.
module tb_aes_round_sequencer;

    localparam int NR = 10;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] data_in;
    logic         busy;
    logic         done;
    logic [127:0] data_out;
    logic         stage_start;
    logic [1:0]   stage_sel;
    logic [127:0] stage_data;
    logic [127:0] stage_result;
    logic         stage_done;
    logic [3:0]   round;

    int checks;
    int errors;

    logic [7:0]   sbox_t [256];
    logic [127:0] rk [11];

    int  lat_max;
    bit  spur;
    int  tr_sel [$];
    int  tr_rnd [$];
    int  tr_lat [$];
    int  exp_sel [$];
    int  exp_rnd [$];

    aes_round_sequencer #(.WORD_SIZE(8), .ARRAY_SIZE(16), .NR(NR)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .data_in      (data_in),
        .busy         (busy),
        .done         (done),
        .data_out     (data_out),
        .stage_start  (stage_start),
        .stage_sel    (stage_sel),
        .stage_data   (stage_data),
        .stage_result (stage_result),
        .stage_done   (stage_done),
        .round        (round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] v);
        logic [7:0] inv;
        logic [7:0] r;
        logic [7:0] s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, v);
        s = inv;
        r = inv;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_t[gb(s, i)];
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int row = 0; row < 4; row++)
            for (int c = 0; c < 4; c++)
                r[127-8*(row+4*c) -: 8] = gb(s, row + 4*((c+row) % 4));
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
            r[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            r[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            r[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            r[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return r;
    endfunction

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r <= NR; r++) begin
            s = shift_rows(sub_bytes(s));
            if (r < NR) s = mix_columns(s);
            s = s ^ rk[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] stage_op(input logic [1:0] sel, input logic [127:0] d,
                                              input logic [3:0] rnd);
        case (sel)
            2'd0: return sub_bytes(d);
            2'd1: return shift_rows(d);
            2'd2: return mix_columns(d);
            default: return (int'(rnd) <= NR) ? (d ^ rk[rnd]) : 'x;
        endcase
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- stage unit model ----------------
    initial begin : responder
        int           cnt;
        logic [1:0]   hsel;
        logic [127:0] hdata;
        logic [127:0] res;
        bit           stale;
        cnt = 0; stale = 1'b0; hsel = 2'd0; hdata = '0; res = '0;
        stage_done = 1'b0;
        stage_result = '0;
        forever begin
            @(posedge clk);
            if (rst === 1'b1) stale = 1'b1;
            #1;
            stage_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (!stale) begin
                    checks++;
                    if (stage_sel !== hsel || stage_data !== hdata) begin
                        errors++;
                        $display("FAIL wait_stable: sel=%0d data=%h required sel=%0d data=%h",
                                 stage_sel, stage_data, hsel, hdata);
                    end
                end
                if (cnt == 0) begin
                    stage_done = 1'b1;
                    stage_result = res;
                end
            end else if (stage_start === 1'b1) begin
                hsel = stage_sel;
                hdata = stage_data;
                res = stage_op(stage_sel, stage_data, round);
                stale = 1'b0;
                cnt = (lat_max <= 1) ? 1 : int'($urandom_range(lat_max, 1));
                tr_sel.push_back(int'(stage_sel));
                tr_rnd.push_back(int'(round));
                tr_lat.push_back(cnt);
                if (spur) begin
                    stage_done = 1'b1;
                    stage_result = rnd128();
                end
            end else if (spur && busy === 1'b0) begin
                stage_done = 1'b1;
                stage_result = rnd128();
            end
        end
    end

    // Runs one block starting in the next cycle; k counts cycles from acceptance.
    task automatic run_block(input logic [127:0] pt, input bit spur_start,
                             output logic [127:0] ct, output int done_k,
                             output int busy_bad, output int hold_bad,
                             output logic [127:0] held);
        int k;
        @(posedge clk); #1;
        tr_sel.delete(); tr_rnd.delete(); tr_lat.delete();
        held = data_out; busy_bad = 0; hold_bad = 0; done_k = -1; ct = 'x;
        start = 1'b1; data_in = pt; k = 0;
        if (busy !== 1'b0) busy_bad++;
        while (k < 3000) begin
            @(posedge clk); #1; k++;
            start = spur_start && (k == 5 || k == 40);
            if (start) data_in = rnd128();
            if (done === 1'b1) begin
                done_k = k;
                ct = data_out;
                if (busy !== 1'b0) busy_bad++;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            if (data_out !== held) hold_bad++;
        end
        start = 1'b0;
    endtask

    function automatic int exp_latency();
        int e;
        e = 1;
        foreach (tr_lat[i]) e += 1 + tr_lat[i];
        return e;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (stage_start !== 1'b0) begin errors++; $display("FAIL reset_stage_start: got %b required 0", stage_start); end
        checks++; if (stage_sel !== 2'd0) begin errors++; $display("FAIL reset_stage_sel: got %0d required 0", stage_sel); end
        checks++; if (stage_data !== '0) begin errors++; $display("FAIL reset_stage_data: got %h required 0", stage_data); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out: got %h required 0", data_out); end
        checks++; if (round !== 4'd0) begin errors++; $display("FAIL reset_round: got %0d required 0", round); end
        rst = 1'b0;
    endtask

    task automatic test_fips();
        logic [127:0] ct, held;
        int done_k, busy_bad, hold_bad, extra;
        lat_max = 1;
        set_key(128'h000102030405060708090a0b0c0d0e0f);
        run_block(128'h00112233445566778899aabbccddeeff, 1'b0, ct, done_k, busy_bad, hold_bad, held);
        checks++; if (ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin errors++; $display("FAIL fips_ct: got %h required 69c4e0d86a7b0430d8cdb78070b4c55a", ct); end
        checks++; if (done_k != 81) begin errors++; $display("FAIL fips_done_cycle: got %0d required 81", done_k); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL fips_busy_window: %0d bad cycles required 0", busy_bad); end
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL fips_data_out_hold: %0d bad cycles required 0", hold_bad); end
        extra = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done !== 1'b0) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL fips_single_done: %0d extra pulses required 0", extra); end
    endtask

    task automatic test_op_trace();
        logic [127:0] pt, ct, held;
        int done_k, busy_bad, hold_bad, mism, first, mix_last;
        lat_max = 1;
        set_key(rnd128());
        pt = rnd128();
        run_block(pt, 1'b0, ct, done_k, busy_bad, hold_bad, held);
        checks++; if (ct !== aes_encrypt(pt)) begin errors++; $display("FAIL trace_ct: got %h required %h", ct, aes_encrypt(pt)); end
        checks++; if (tr_sel.size() != 40) begin errors++; $display("FAIL trace_op_count: got %0d required 40", tr_sel.size()); end
        mism = 0; first = -1; mix_last = 0;
        for (int i = 0; i < tr_sel.size() && i < exp_sel.size(); i++) begin
            if (tr_sel[i] != exp_sel[i] || tr_rnd[i] != exp_rnd[i]) begin
                mism++;
                if (first < 0) first = i;
            end
            if (tr_sel[i] == 2 && tr_rnd[i] == NR) mix_last++;
        end
        checks++; if (mism != 0) begin errors++; $display("FAIL trace_sequence: %0d mismatching ops (first at %0d) required 0", mism, first); end
        checks++; if (mix_last != 0) begin errors++; $display("FAIL trace_mix_last_round: got %0d required 0", mix_last); end
    endtask

    task automatic test_var_latency();
        logic [127:0] pt, ct, held;
        int done_k, busy_bad, hold_bad;
        lat_max = 7;
        for (int b = 0; b < 3; b++) begin
            set_key(rnd128());
            pt = rnd128();
            run_block(pt, 1'b0, ct, done_k, busy_bad, hold_bad, held);
            checks++; if (ct !== aes_encrypt(pt)) begin errors++; $display("FAIL varlat_ct[%0d]: got %h required %h", b, ct, aes_encrypt(pt)); end
            checks++; if (done_k != exp_latency()) begin errors++; $display("FAIL varlat_done_cycle[%0d]: got %0d required %0d", b, done_k, exp_latency()); end
            checks++; if (busy_bad != 0) begin errors++; $display("FAIL varlat_busy[%0d]: %0d bad cycles required 0", b, busy_bad); end
        end
    endtask

    task automatic test_spurious();
        logic [127:0] p1, p2, ct, held;
        int done_k, busy_bad, hold_bad, mism;
        lat_max = 3;
        spur = 1'b1;
        set_key(rnd128());
        p1 = rnd128(); p2 = rnd128();
        run_block(p1, 1'b1, ct, done_k, busy_bad, hold_bad, held);
        checks++; if (ct !== aes_encrypt(p1)) begin errors++; $display("FAIL spur_ct1: got %h required %h", ct, aes_encrypt(p1)); end
        checks++; if (done_k != exp_latency()) begin errors++; $display("FAIL spur_done_cycle1: got %0d required %0d", done_k, exp_latency()); end
        mism = (tr_sel.size() != 40) ? 1 : 0;
        for (int i = 0; i < tr_sel.size() && i < 40; i++)
            if (tr_sel[i] != exp_sel[i] || tr_rnd[i] != exp_rnd[i]) mism++;
        checks++; if (mism != 0) begin errors++; $display("FAIL spur_trace: %0d mismatches required 0", mism); end
        start = 1'b1;
        data_in = rnd128();
        run_block(p2, 1'b1, ct, done_k, busy_bad, hold_bad, held);
        checks++; if (ct !== aes_encrypt(p2)) begin errors++; $display("FAIL spur_ct2: got %h required %h", ct, aes_encrypt(p2)); end
        checks++; if (done_k != exp_latency()) begin errors++; $display("FAIL spur_done_cycle2: got %0d required %0d", done_k, exp_latency()); end
        spur = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [127:0] pt, ct, held;
        int done_k, busy_bad, hold_bad, quiet_bad;
        lat_max = 7;
        set_key(rnd128());
        @(posedge clk); #1;
        start = 1'b1; data_in = rnd128();
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 30) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b required 0", done); end
        checks++; if (stage_start !== 1'b0) begin errors++; $display("FAIL abort_stage_start: got %b required 0", stage_start); end
        checks++; if (stage_sel !== 2'd0) begin errors++; $display("FAIL abort_stage_sel: got %0d required 0", stage_sel); end
        checks++; if (stage_data !== '0) begin errors++; $display("FAIL abort_stage_data: got %h required 0", stage_data); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL abort_data_out: got %h required 0", data_out); end
        checks++; if (round !== 4'd0) begin errors++; $display("FAIL abort_round: got %0d required 0", round); end
        quiet_bad = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || done !== 1'b0 || stage_start !== 1'b0 || stage_data !== '0) quiet_bad++;
        end
        checks++; if (quiet_bad != 0) begin errors++; $display("FAIL abort_late_done_ignored: %0d active cycles required 0", quiet_bad); end
        lat_max = 1;
        pt = rnd128();
        run_block(pt, 1'b0, ct, done_k, busy_bad, hold_bad, held);
        checks++; if (ct !== aes_encrypt(pt)) begin errors++; $display("FAIL abort_recover_ct: got %h required %h", ct, aes_encrypt(pt)); end
        checks++; if (done_k != 81) begin errors++; $display("FAIL abort_recover_cycle: got %0d required 81", done_k); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] p1, p2, ct1, ct2, held;
        int done_k, busy_bad, hold_bad;
        lat_max = 2;
        set_key(rnd128());
        p1 = rnd128(); p2 = rnd128();
        run_block(p1, 1'b0, ct1, done_k, busy_bad, hold_bad, held);
        checks++; if (ct1 !== aes_encrypt(p1)) begin errors++; $display("FAIL b2b_ct1: got %h required %h", ct1, aes_encrypt(p1)); end
        run_block(p2, 1'b0, ct2, done_k, busy_bad, hold_bad, held);
        checks++; if (ct2 !== aes_encrypt(p2)) begin errors++; $display("FAIL b2b_ct2: got %h required %h", ct2, aes_encrypt(p2)); end
        checks++; if (held !== aes_encrypt(p1)) begin errors++; $display("FAIL b2b_held_value: got %h required %h", held, aes_encrypt(p1)); end
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL b2b_hold: %0d changed cycles required 0", hold_bad); end
        checks++; if (done_k != exp_latency()) begin errors++; $display("FAIL b2b_done_cycle: got %0d required %0d", done_k, exp_latency()); end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        checks = 0; errors = 0;
        lat_max = 1; spur = 1'b0;
        rst = 1'b1; start = 1'b0; data_in = '0;
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
        for (int r = 0; r <= NR; r++) begin
            if (r == 0) begin
                exp_sel.push_back(3); exp_rnd.push_back(0);
            end else begin
                exp_sel.push_back(0); exp_rnd.push_back(r);
                exp_sel.push_back(1); exp_rnd.push_back(r);
                if (r < NR) begin exp_sel.push_back(2); exp_rnd.push_back(r); end
                exp_sel.push_back(3); exp_rnd.push_back(r);
            end
        end
        test_reset();
        test_fips();
        test_op_trace();
        test_var_latency();
        test_spurious();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
